controle_somatorio: RTL and testbench
=====================================

Name: controle_somatorio

Overview:
- Sequencer for the accumulate-and-signal datapath: collects a fixed number of 8-bit parcels into a saturating 8-bit sum.
- Compares the sum against a threshold and drives the status LED.
- Sits between the input capture logic (switch/button values with a valid strobe) and the signalling comparator, which continues to receive somatorio.
- The LED is generated here from a registered compare so it is glitch-free and held until cleared.

Parameters:
- LIMIAR, 99, threshold; led asserts when the final somatorio >= LIMIAR (8-bit unsigned).
- N_PARCELAS, 10, number of parcels accumulated per run; legal range 1..15.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- iniciar  input  1  start a new run (level sampled per cycle)
- limpar  input  1  abort/clear, returns to OCIOSO
- finalizar  input  1  end accumulation early, go straight to compare
- valor  input  8  parcel value, unsigned
- valor_valido  input  1  one-cycle strobe qualifying valor
- somatorio  output  8  running/final sum (registered)
- conta_parcelas  output  4  parcels accepted in the current run
- ocupado  output  1  high in ACUMULA and COMPARA
- transbordo  output  1  sticky: a saturating add clipped at 255 during this run
- pronto  output  1  one-cycle pulse on entry to SINALIZA
- led  output  1  registered result: somatorio >= LIMIAR

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=OCIOSO.
  - somatorio=0, conta_parcelas=0, transbordo=0, led=0, pronto=0, ocupado=0.
  - Reset overrides every other input, in any state.
- Priority each cycle: rst_n > limpar > iniciar > finalizar > valor_valido.
- OCIOSO:
  - Outputs hold their last values (a finished result stays visible).
  - iniciar=1 -> ACUMULA next cycle, with somatorio=0, conta_parcelas=0, transbordo=0, led=0.
  - valor_valido is ignored.
- ACUMULA:
  - Each valor_valido=1 cycle:
    - 9-bit sum s = somatorio + valor.
    - If s[8]=1: somatorio<=255 and transbordo<=1; otherwise somatorio<=s[7:0].
    - conta_parcelas increments.
  - The add is visible on somatorio the cycle after the strobe (latency 1).
  - When the accepted parcel makes conta_parcelas == N_PARCELAS -> COMPARA next cycle.
  - finalizar=1 -> COMPARA next cycle.
    - If valor_valido is also 1 that cycle, the parcel is still accumulated.
  - iniciar is ignored while in ACUMULA; it does not restart the run.
  - Once conta_parcelas == N_PARCELAS, further strobes are impossible because the state has already left ACUMULA.
- COMPARA (exactly 1 cycle):
  - led <= (somatorio >= LIMIAR), unsigned compare; equality counts as reached.
  - Inputs are ignored except limpar and rst_n.
  - Always -> SINALIZA.
- SINALIZA:
  - pronto=1 on the first cycle only.
  - led, somatorio, conta_parcelas and transbordo are held.
  - iniciar=1 -> ACUMULA, with the same clears as from OCIOSO, led<=0.
  - limpar=1 -> OCIOSO.
  - valor_valido and finalizar are ignored.
- limpar=1 in any state -> OCIOSO next cycle, with somatorio=0, conta_parcelas=0, transbordo=0, led=0, pronto=0.
- ocupado is a registered decode: 1 exactly when state is ACUMULA or COMPARA.
- Reset or limpar mid-run discards the partial sum; no pronto pulse is emitted.
- Unused state encodings recover to OCIOSO on the next clock.

Test Plan:
- Reset, then iniciar, then 10 strobes of valor=10 -> somatorio=100 after the 10th; COMPARA; led=1; pronto pulses once; transbordo=0; conta_parcelas=10.
- Threshold edge: 9 strobes of valor=11 -> somatorio=99, then finalizar -> led=1; repeat with the last value 10 (sum 98) -> led=0.
- Saturation: iniciar, strobes 200 then 100 then 50 -> somatorio=255 after the 2nd strobe and stays 255; transbordo=1; finalizar -> led=1.
- finalizar in the same cycle as valor_valido=7 after two parcels of 5 -> somatorio=17, conta_parcelas=3, COMPARA next cycle, led=0.
- limpar in the middle of ACUMULA (sum 60), also with iniciar=1 that cycle -> OCIOSO; all outputs 0; no pronto; a following iniciar starts from 0.
- rst_n=0 held for one cycle while in SINALIZA with led=1 -> all outputs 0 the next cycle; state OCIOSO; strobes ignored until iniciar.

Source files
------------

// File: rtl/controle_somatorio.sv
// Accumulate-and-signal sequencer: sums N_PARCELAS 8-bit parcels with saturation,
// then registers a threshold compare that drives the status LED.
module controle_somatorio #(
  parameter int unsigned LIMIAR     = 99,
  parameter int unsigned N_PARCELAS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iniciar,
  input  logic       limpar,
  input  logic       finalizar,
  input  logic [7:0] valor,
  input  logic       valor_valido,
  output logic [7:0] somatorio,
  output logic [3:0] conta_parcelas,
  output logic       ocupado,
  output logic       transbordo,
  output logic       pronto,
  output logic       led
);

  localparam logic [7:0] Limiar8 = 8'(LIMIAR);
  localparam logic [3:0] NParc4  = 4'(N_PARCELAS);

  typedef enum logic [1:0] {
    StOcioso,
    StAcumula,
    StCompara,
    StSinaliza
  } estado_t;

  estado_t estado_q, estado_d;

  logic [8:0] soma;
  logic [3:0] conta_inc;
  logic       ultima;

  assign soma      = {1'b0, somatorio} + {1'b0, valor};
  assign conta_inc = conta_parcelas + 4'd1;
  assign ultima    = valor_valido && (conta_inc == NParc4);

  always_comb begin
    estado_d = estado_q;
    if (limpar) begin
      estado_d = StOcioso;
    end else begin
      case (estado_q)
        StOcioso:   if (iniciar) estado_d = StAcumula;
        StAcumula:  if (finalizar || ultima) estado_d = StCompara;
        StCompara:  estado_d = StSinaliza;
        StSinaliza: if (iniciar) estado_d = StAcumula;
        default:    estado_d = StOcioso;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) estado_q <= StOcioso;
    else        estado_q <= estado_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      somatorio      <= 8'd0;
      conta_parcelas <= 4'd0;
      transbordo     <= 1'b0;
      led            <= 1'b0;
      pronto         <= 1'b0;
      ocupado        <= 1'b0;
    end else begin
      // Decoded from the next state so both flags line up with the state register.
      ocupado <= (estado_d == StAcumula) || (estado_d == StCompara);
      pronto  <= (estado_d == StSinaliza) && (estado_q != StSinaliza);
      if (limpar) begin
        somatorio      <= 8'd0;
        conta_parcelas <= 4'd0;
        transbordo     <= 1'b0;
        led            <= 1'b0;
      end else begin
        case (estado_q)
          StOcioso, StSinaliza: begin
            if (iniciar) begin
              somatorio      <= 8'd0;
              conta_parcelas <= 4'd0;
              transbordo     <= 1'b0;
              led            <= 1'b0;
            end
          end
          StAcumula: begin
            if (valor_valido) begin
              conta_parcelas <= conta_inc;
              if (soma[8]) begin
                somatorio  <= 8'hFF;
                transbordo <= 1'b1;
              end else begin
                somatorio <= soma[7:0];
              end
            end
          end
          StCompara: led <= (somatorio >= Limiar8);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_controle_somatorio.sv
// Scoreboard bench: each run pushes its expected final result; a monitor pops and
// compares whenever pronto pulses. Direct checks cover reset and clear behaviour.
module tb_controle_somatorio;

  logic       clk = 1'b0;
  logic       rst_n, iniciar, limpar, finalizar, valor_valido;
  logic [7:0] valor;
  logic [7:0] somatorio;
  logic [3:0] conta_parcelas;
  logic       ocupado, transbordo, pronto, led;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] som;
    logic [3:0] cnt;
    logic       tr;
    logic       led;
  } exp_t;

  exp_t fila[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  controle_somatorio #(.LIMIAR(99), .N_PARCELAS(10)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .iniciar        (iniciar),
    .limpar         (limpar),
    .finalizar      (finalizar),
    .valor          (valor),
    .valor_valido   (valor_valido),
    .somatorio      (somatorio),
    .conta_parcelas (conta_parcelas),
    .ocupado        (ocupado),
    .transbordo     (transbordo),
    .pronto         (pronto),
    .led            (led)
  );

  task automatic chk(input string nome, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nome, act, exp);
    end
  endtask

  // Monitor: every pronto pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && pronto === 1'b1) begin
      if (fila.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pronto_inesperado: got pulse expected none (som=%0d)", somatorio);
      end else begin
        mon_e = fila.pop_front();
        chk("res_somatorio", int'(somatorio), int'(mon_e.som));
        chk("res_conta", int'(conta_parcelas), int'(mon_e.cnt));
        chk("res_transbordo", int'(transbordo), int'(mon_e.tr));
        chk("res_led", int'(led), int'(mon_e.led));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic inicia();
    iniciar = 1'b1;
    tick(1);
    iniciar = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] v);
    valor        = v;
    valor_valido = 1'b1;
    tick(1);
    valor_valido = 1'b0;
  endtask

  task automatic finaliza();
    finalizar = 1'b1;
    tick(1);
    finalizar = 1'b0;
  endtask

  task automatic espera_resultado(input string nome);
    tick(3);
    chk(nome, fila.size(), 0);
  endtask

  task automatic chk_zeros(input string pre);
    chk({pre, "_somatorio"}, int'(somatorio), 0);
    chk({pre, "_conta"}, int'(conta_parcelas), 0);
    chk({pre, "_transbordo"}, int'(transbordo), 0);
    chk({pre, "_led"}, int'(led), 0);
    chk({pre, "_pronto"}, int'(pronto), 0);
    chk({pre, "_ocupado"}, int'(ocupado), 0);
  endtask

  initial begin
    rst_n = 1'b0; iniciar = 1'b0; limpar = 1'b0; finalizar = 1'b0;
    valor = 8'd0; valor_valido = 1'b0;
    tick(2);
    rst_n = 1'b1;
    chk_zeros("reset");

    // Full run: 10 x 10 = 100, ends on parcel count
    inicia();
    chk("ocupado_acumula", int'(ocupado), 1);
    fila.push_back('{som: 8'd100, cnt: 4'd10, tr: 1'b0, led: 1'b1});
    for (int i = 0; i < 10; i++) strobe(8'd10);
    chk("ocupado_compara", int'(ocupado), 1);
    espera_resultado("fila_run10");
    chk("led_mantido", int'(led), 1);

    // Threshold equality: 9 x 11 = 99
    inicia();
    chk("led_limpo_inicio", int'(led), 0);
    fila.push_back('{som: 8'd99, cnt: 4'd9, tr: 1'b0, led: 1'b1});
    for (int i = 0; i < 9; i++) strobe(8'd11);
    finaliza();
    espera_resultado("fila_99");

    // Just below: 8 x 11 + 10 = 98
    inicia();
    fila.push_back('{som: 8'd98, cnt: 4'd9, tr: 1'b0, led: 1'b0});
    for (int i = 0; i < 8; i++) strobe(8'd11);
    strobe(8'd10);
    finaliza();
    espera_resultado("fila_98");

    // Saturation
    inicia();
    fila.push_back('{som: 8'd255, cnt: 4'd3, tr: 1'b1, led: 1'b1});
    strobe(8'd200);
    strobe(8'd100);
    chk("saturado", int'(somatorio), 255);
    chk("transbordo_set", int'(transbordo), 1);
    strobe(8'd50);
    finaliza();
    espera_resultado("fila_sat");

    // finalizar coincident with a strobe still accumulates it
    inicia();
    fila.push_back('{som: 8'd17, cnt: 4'd3, tr: 1'b0, led: 1'b0});
    strobe(8'd5);
    strobe(8'd5);
    valor = 8'd7; valor_valido = 1'b1; finalizar = 1'b1;
    tick(1);
    valor_valido = 1'b0; finalizar = 1'b0;
    chk("fin_mesmo_ciclo", int'(somatorio), 17);
    espera_resultado("fila_17");

    // limpar (with iniciar) mid-run discards the partial sum
    inicia();
    strobe(8'd30);
    strobe(8'd30);
    chk("parcial_60", int'(somatorio), 60);
    limpar = 1'b1; iniciar = 1'b1;
    tick(1);
    limpar = 1'b0; iniciar = 1'b0;
    chk_zeros("limpar");
    tick(3);
    chk("ocioso_apos_limpar", int'(ocupado), 0);
    inicia();
    fila.push_back('{som: 8'd5, cnt: 4'd1, tr: 1'b0, led: 1'b0});
    strobe(8'd5);
    finaliza();
    espera_resultado("fila_pos_limpar");

    // Reset while in SINALIZA with led=1
    inicia();
    fila.push_back('{som: 8'd150, cnt: 4'd1, tr: 1'b0, led: 1'b1});
    strobe(8'd150);
    finaliza();
    espera_resultado("fila_150");
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk_zeros("reset_sinaliza");
    strobe(8'd50);
    tick(1);
    chk("strobe_ignorado", int'(somatorio), 0);
    chk("strobe_ignorado_conta", int'(conta_parcelas), 0);
    chk("fila_final", fila.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
